ps2_tx: RTL and testbench
=========================

// Module: ps2_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset,
//  0xF4 enable) to a keyboard/mouse over the open-drain ps2c/ps2d pair.
//  Companion to the PS/2 receiver on the same lines. The top level wires busy
//  inverted into the receiver enable, so the receiver never decodes host traffic.
//  Lines are driven low only through *_oe; the top level builds the tristates.
// PARAMETERS
//  FILTER_STEPS    8       ps2c glitch-filter depth in clk cycles (same filter as receiver)
//  INHIBIT_CYCLES  5000    clk cycles ps2c is held low for request-to-send (100 us @ 50 MHz)
//  TIMEOUT_CYCLES  750000  max clk cycles from clock release to ack edge (15 ms @ 50 MHz)
// PORTS
//  clk      in   1  system clock
//  rst      in   1  asynchronous reset, active high
//  ps2c     in   1  PS/2 clock line as seen on the pin
//  ps2d     in   1  PS/2 data line as seen on the pin
//  wr       in   1  start-transmit strobe; sampled only in S_IDLE
//  din      in   8  byte to send; captured on the accepted wr
//  ps2c_oe  out  1  1 = drive ps2c low, 0 = release
//  ps2d_oe  out  1  1 = drive ps2d low, 0 = release
//  busy     out  1  1 in every state except S_IDLE
//  done     out  1  one-cycle pulse: frame sent and device ack seen
//  err      out  1  one-cycle pulse: timeout or missing ack
// BEHAVIOUR
//  Reset (async, immediate):
//   - all outputs 0; lines released mid-frame; state S_IDLE
//   - filter and counters cleared
//  Falling-edge detector:
//   - filter_r shifts ps2c in every cycle
//   - filtered level goes 1 when filter_r is all ones, 0 when all zeros, else holds
//   - fall = one-cycle tick on filtered 1->0
//   - fall is ignored in S_IDLE and S_RTS (the self-inflicted low in S_RTS is ignored)
//  Frame register:
//   - sh_r[8:0] = {~^din, din}, odd parity, loaded on the accepted wr
//   - bit counter idx_r is 4 bits
//  FSM (registered state, one cycle per transition):
//   S_IDLE:  wr=1 -> load sh_r, cnt=0, go S_RTS; wr=0 -> stay
//   S_RTS:   ps2c_oe=1, ps2d_oe=0; cnt counts up
//            at cnt==INHIBIT_CYCLES-1 -> go S_START, cnt=0
//   S_START: ps2c_oe=0, ps2d_oe=1 (start bit 0); device now generates clocks
//            fall -> ps2d_oe=~sh_r[0], shift sh_r right, idx=1, go S_DATA
//   S_DATA:  on each fall with idx<=8: ps2d_oe=~sh_r[0], shift, idx++
//            (idx 1..7 drive d1..d7; idx 8 drives parity)
//            fall at idx==9: ps2d_oe=0 (stop bit 1), go S_ACK
//   S_ACK:   lines released; next fall samples ps2d
//            ps2d==0 -> go S_DONE; ps2d==1 -> go S_ERR
//   S_DONE:  done=1 for one cycle -> S_IDLE
//   S_ERR:   err=1 for one cycle -> S_IDLE; both oe already 0
//  Timeout:
//   - cnt restarts at 0 on entering S_START, runs through S_START/S_DATA/S_ACK
//   - cnt==TIMEOUT_CYCLES-1 -> S_ERR, lines released
//  Counter width: $clog2(max(INHIBIT_CYCLES,TIMEOUT_CYCLES)+1); no wrap can occur.
//  Data changes only in the cycle after a filtered falling edge; the device
//   samples on the rising edge, so the half-period setup is inherent.
//  Latency wr -> done: INHIBIT_CYCLES + 11 device clocks + filter delay + 2 cycles.
//  Simultaneous events:
//   - wr while busy is dropped; din changes while busy have no effect
//   - fall coinciding with timeout: timeout wins
// TESTING
//  1. wr, din=0xF4 -> ps2c_oe high for exactly 5000 cycles; device model
//     samples 0,0,0,1,0,1,1,1,1,par=0,stop=1; acks -> done pulse, busy falls.
//  2. din=0x00 -> parity bit 1; din=0xFF -> parity bit 1; din=0x01 -> parity 0.
//  3. Device model never clocks after release -> err pulse exactly 750000 cycles
//     after S_START entry; both oe=0.
//  4. Device leaves ps2d high at clock 11 -> err pulse, no done.
//  5. Glitches of <8 cycles on ps2c in S_DATA -> no extra shifts; frame intact.
//  6. rst asserted at bit 4 -> oe both 0 same cycle; next wr 0xFF sends cleanly;
//     a wr pulse while busy is ignored.

Source files
------------

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the attached device:
// request-to-send by inhibiting ps2c, start bit, eight data bits LSB first, odd
// parity, stop bit, then the device acknowledge. Lines are only ever pulled low
// through the *_oe outputs; the surrounding level builds the open-drain pads.
//
//  state   | meaning
//  S_IDLE  | lines released, waiting for wr
//  S_RTS   | ps2c held low for INHIBIT_CYCLES (request-to-send)
//  S_START | ps2c released, ps2d low (start bit), waiting for first device clock
//  S_DATA  | data/parity/stop bits presented after each filtered falling edge
//  S_ACK   | lines released, next falling edge samples the device ack
//  S_DONE  | one-cycle done pulse
//  S_ERR   | one-cycle err pulse (timeout or missing ack)
`timescale 1ns/1ps

module ps2_tx #(
  parameter int FILTER_STEPS   = 8,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       wr,
  input  logic [7:0] din,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // One counter serves both the inhibit interval and the frame timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RTS,
    S_START,
    S_DATA,
    S_ACK,
    S_DONE,
    S_ERR
  } state_t;

  state_t                  state;
  logic [FILTER_STEPS-1:0] filter_r;
  logic                    filt_r;
  logic                    filt_next;
  logic                    fall_r;
  logic [1:0]              d_sync_r;
  logic [8:0]              sh_r;
  logic [3:0]              idx_r;
  logic [CW-1:0]           cnt_r;

  // Filtered ps2c level: changes only after FILTER_STEPS identical samples.
  always_comb begin
    filt_next = filt_r;
    if (&filter_r)
      filt_next = 1'b1;
    else if (~|filter_r)
      filt_next = 1'b0;
  end

  // Glitch filter history, filtered level and the one-cycle falling-edge tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filter_r <= '0;
      filt_r   <= 1'b0;
      fall_r   <= 1'b0;
    end else begin
      filter_r <= {filter_r[FILTER_STEPS-2:0], ps2c};
      filt_r   <= filt_next;
      fall_r   <= filt_r & ~filt_next;
    end
  end

  // Two-flop synchroniser for the ack sample on ps2d.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      d_sync_r <= 2'b11;
    else
      d_sync_r <= {d_sync_r[0], ps2d};
  end

  // Transmit sequencer with registered line enables and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sh_r    <= '0;
      idx_r   <= '0;
      cnt_r   <= '0;
      ps2c_oe <= 1'b0;
      ps2d_oe <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done    <= 1'b0;
          err     <= 1'b0;
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          if (wr) begin
            sh_r    <= {~^din, din};
            idx_r   <= '0;
            cnt_r   <= '0;
            ps2c_oe <= 1'b1;
            busy    <= 1'b1;
            state   <= S_RTS;
          end
        end

        S_RTS: begin
          if (cnt_r == INH_LAST) begin
            cnt_r   <= '0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b1;
            state   <= S_START;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end

        S_START: begin
          if (cnt_r == TO_LAST) begin
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= S_ERR;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (fall_r) begin
              ps2d_oe <= ~sh_r[0];
              sh_r    <= {1'b0, sh_r[8:1]};
              idx_r   <= 4'd1;
              state   <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (cnt_r == TO_LAST) begin
            ps2d_oe <= 1'b0;
            err     <= 1'b1;
            state   <= S_ERR;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (fall_r) begin
              if (idx_r <= 4'd8) begin
                // idx 1..7 present d1..d7, idx 8 presents the parity bit
                ps2d_oe <= ~sh_r[0];
                sh_r    <= {1'b0, sh_r[8:1]};
                idx_r   <= idx_r + 1'b1;
              end else begin
                // stop bit is a released (high) line
                ps2d_oe <= 1'b0;
                state   <= S_ACK;
              end
            end
          end
        end

        S_ACK: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          if (cnt_r == TO_LAST) begin
            err   <= 1'b1;
            state <= S_ERR;
          end else begin
            cnt_r <= cnt_r + 1'b1;
            if (fall_r) begin
              if (!d_sync_r[1]) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                err   <= 1'b1;
                state <= S_ERR;
              end
            end
          end
        end

        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        S_ERR: begin
          err     <= 1'b0;
          busy    <= 1'b0;
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          ps2c_oe <= 1'b0;
          ps2d_oe <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a behavioural PS/2 device clocks frames out of the DUT,
// expected outcomes are queued at stimulus time and checked by a monitor on
// each done/err pulse.
`timescale 1ns/1ps

module tb_ps2_tx;

  localparam int FILTER  = 8;
  localparam int INHIBIT = 50;
  localparam int TIMEOUT = 3000;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c, ps2d;
  logic       ps2c_oe, ps2d_oe, busy, done, err;

  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  logic glitch    = 1'b0;

  assign ps2c = ~(ps2c_oe | dev_c_low | glitch);
  assign ps2d = ~(ps2d_oe | dev_d_low);

  ps2_tx #(
    .FILTER_STEPS  (FILTER),
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ps2c   (ps2c),
    .ps2d   (ps2d),
    .wr     (wr),
    .din    (din),
    .ps2c_oe(ps2c_oe),
    .ps2d_oe(ps2d_oe),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    bit          chk;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [10:0] dev_rx = '0;
  int          cyc = 0;
  int          t_rel = 0;
  int          t_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every done/err pulse consumes one expected outcome.
  initial begin
    exp_t e;
    logic prev_c_oe;
    logic prev_err;
    prev_c_oe = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_c_oe && !ps2c_oe) t_rel = cyc;
      if (err && !prev_err) t_err = cyc;
      prev_c_oe = ps2c_oe;
      prev_err  = err;
      if (!rst && (done || err)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got done=%0b err=%0b expected no pulse", done, err);
        end else begin
          e = exp_q.pop_front();
          check("outcome_err", {31'b0, err}, {31'b0, e.is_err});
          check("outcome_done", {31'b0, done}, {31'b0, !e.is_err});
          if (e.chk) check("frame_bits", {21'b0, dev_rx}, {21'b0, e.frame});
          if (err) check("err_lines_released", {30'b0, ps2c_oe, ps2d_oe}, 32'd0);
        end
      end
    end
  end

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("busy_clears", {31'b0, busy}, 32'd0);
    repeat (30) @(negedge clk);
  endtask

  // One host transmission against the device model.
  // ack: device drives ack; glitch: short ps2c glitches in two high phases;
  // abort_k: assert rst after sampling this device clock (0 = never);
  // clocks: device generates clocks at all; poke: wr/din activity while busy.
  task automatic run_frame(input logic [7:0] d, input logic par, input bit ack,
                           input bit glt, input int abort_k, input bit clocks,
                           input bit poke);
    int n;
    if (abort_k == 0) begin
      if (!clocks) exp_q.push_back('{1'b1, 1'b0, 11'h0});
      else         exp_q.push_back('{!ack, 1'b1, {1'b1, par, d, 1'b0}});
    end
    dev_rx = '0;
    @(negedge clk);
    wr  = 1'b1;
    din = d;
    @(negedge clk);
    wr = 1'b0;
    n = 0;
    while (ps2c_oe && n < INHIBIT * 4) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_len", n, INHIBIT);
    if (!clocks) return;
    if (poke) begin
      wr  = 1'b1;
      din = 8'h55;
      @(negedge clk);
      wr = 1'b0;
      repeat (HALF - 1) @(negedge clk);
    end else begin
      repeat (HALF) @(negedge clk);
    end
    dev_rx[0] = ps2d;
    for (int k = 1; k <= 10; k++) begin
      dev_c_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_c_low = 1'b0;
      @(negedge clk);
      dev_rx[k] = ps2d;
      if (k == abort_k) begin
        check("pre_rst_d_oe", {31'b0, ps2d_oe}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_oe_same_cycle", {29'b0, ps2c_oe, ps2d_oe, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (glt && (k == 3 || k == 5)) begin
        repeat (4) @(negedge clk);
        glitch = 1'b1;
        repeat (4) @(negedge clk);
        glitch = 1'b0;
        repeat (HALF - 9) @(negedge clk);
      end else begin
        repeat (HALF - 1) @(negedge clk);
      end
    end
    dev_d_low = ack;
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_c_low = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_d_low = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_outputs", {27'b0, ps2c_oe, ps2d_oe, busy, done, err}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_outputs", {27'b0, ps2c_oe, ps2d_oe, busy, done, err}, 32'd0);

    // byte, parity, ack, glitch, abort_k, clocks, poke
    run_frame(8'hF4, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0); wait_idle(2000);
    run_frame(8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0); wait_idle(2000);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0); wait_idle(2000);
    run_frame(8'h01, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0); wait_idle(2000);

    run_frame(8'hF4, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0); wait_idle(10000);
    check("timeout_cycles", t_err - t_rel, TIMEOUT);

    run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0); wait_idle(2000);
    run_frame(8'h5A, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0); wait_idle(2000);

    run_frame(8'hF4, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0); wait_idle(2000);
    run_frame(8'hFF, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1); wait_idle(2000);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
